// File: rtl/pc_redirect_sequencer.sv
// Fetch-PC redirect sequencer: arbitrates MEM/EX/ID redirects, parks one while fetch stalls,
// drives PC load/hold and stage flushes. Optional perf counters behind `PC_SEQ_PERF_EN.
module pc_redirect_sequencer #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned PERF_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_cur,
   input  logic            imem_ready,
   input  logic            hazard_stall,
   input  logic            mem_mispredict,
   input  logic [XLEN-1:0] mem_pc,
   input  logic            ex_redirect,
   input  logic [XLEN-1:0] ex_target,
   input  logic            id_jump,
   input  logic [XLEN-1:0] id_offset,
   output logic            pc_load,
   output logic [XLEN-1:0] pc_next,
   output logic            pc_hold,
   output logic            flush_if,
   output logic            flush_id,
   output logic            flush_ex,
   output logic [1:0]      seq_state
`ifdef PC_SEQ_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_redirects,
   output logic [PERF_W-1:0] perf_hold_cycles
`endif
);

   typedef enum logic [1:0] {
      StRun   = 2'b00,
      StPend  = 2'b01,
      StDrain = 2'b10
   } seq_state_e;

   // Encoding doubles as priority: larger value wins.
   typedef enum logic [1:0] {
      SrcNone = 2'd0,
      SrcId   = 2'd1,
      SrcEx   = 2'd2,
      SrcMem  = 2'd3
   } src_e;

   seq_state_e      state_q, state_d;
   src_e            slot_src_q, slot_src_d;
   logic [XLEN-1:0] slot_tgt_q, slot_tgt_d;

   src_e            req_src;
   logic [XLEN-1:0] req_tgt;
   src_e            win_src;
   logic [XLEN-1:0] win_tgt;
   logic            id_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         slot_src_q <= SrcNone;
         slot_tgt_q <= '0;
      end else begin
         state_q    <= state_d;
         slot_src_q <= slot_src_d;
         slot_tgt_q <= slot_tgt_d;
      end
   end

   // Fresh request of this cycle, fixed priority MEM > EX > ID.
   always_comb begin
      req_src = SrcNone;
      req_tgt = '0;
      id_ok   = id_jump && !hazard_stall && (state_q != StDrain);
      if (mem_mispredict) begin
         req_src = SrcMem;
         req_tgt = mem_pc + XLEN'(4);
      end else if (ex_redirect) begin
         req_src = SrcEx;
         req_tgt = ex_target;
      end else if (id_ok) begin
         req_src = SrcId;
         req_tgt = pc_cur + id_offset - XLEN'(4);
      end
   end

   // A parked redirect only yields to a strictly higher-priority newcomer.
   always_comb begin
      win_src = req_src;
      win_tgt = req_tgt;
      if ((state_q == StPend) && (slot_src_q >= req_src)) begin
         win_src = slot_src_q;
         win_tgt = slot_tgt_q;
      end
   end

   always_comb begin
      state_d    = StRun;
      slot_src_d = SrcNone;
      slot_tgt_d = '0;
      pc_load    = 1'b0;
      pc_next    = '0;
      pc_hold    = 1'b0;
      flush_if   = 1'b0;
      flush_id   = 1'b0;
      flush_ex   = 1'b0;
      seq_state  = state_q;

      if (rst) begin
         pc_hold   = 1'b1;
         seq_state = StRun;
      end else if (win_src != SrcNone) begin
         if (imem_ready) begin
            pc_load  = 1'b1;
            pc_next  = win_tgt;
            flush_if = 1'b1;
            unique case (win_src)
               SrcMem: begin
                  flush_id = 1'b1;
                  flush_ex = 1'b1;
               end
               SrcEx:   flush_id = 1'b1;
               default: ;
            endcase
            state_d = StDrain;
         end else begin
            pc_hold    = 1'b1;
            state_d    = StPend;
            slot_src_d = win_src;
            slot_tgt_d = win_tgt;
         end
      end else begin
         // Reachable from RUN or DRAIN only; PEND always holds a valid slot.
         pc_hold = hazard_stall | ~imem_ready;
         state_d = StRun;
      end
   end

`ifdef PC_SEQ_PERF_EN
   logic [PERF_W-1:0] perf_redir_q, perf_hold_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_redir_q <= '0;
         perf_hold_q  <= '0;
      end else begin
         if (pc_load && (perf_redir_q != '1)) begin
            perf_redir_q <= perf_redir_q + PERF_W'(1);
         end
         if (pc_hold && (perf_hold_q != '1)) begin
            perf_hold_q <= perf_hold_q + PERF_W'(1);
         end
      end
   end

   assign perf_redirects   = perf_redir_q;
   assign perf_hold_cycles = perf_hold_q;
`endif

   a_load_hold_excl : assert property (@(posedge clk) !(pc_load && pc_hold));
   a_next_zero_idle : assert property (@(posedge clk) pc_load || (pc_next == '0));

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Random + directed bench for pc_redirect_sequencer against a behavioural redirect model.
module tb_pc_redirect_sequencer;

   logic        clk = 1'b0;
   logic        rst, imem_ready, hazard_stall, mem_mispredict, ex_redirect, id_jump;
   logic [31:0] pc_cur, mem_pc, ex_target, id_offset;
   logic        pc_load, pc_hold, flush_if, flush_id, flush_ex;
   logic [31:0] pc_next;
   logic [1:0]  seq_state;
`ifdef PC_SEQ_PERF_EN
   logic [31:0] perf_redirects, perf_hold_cycles;
`endif

   pc_redirect_sequencer #(.XLEN(32), .PERF_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_cur        (pc_cur),
      .imem_ready    (imem_ready),
      .hazard_stall  (hazard_stall),
      .mem_mispredict(mem_mispredict),
      .mem_pc        (mem_pc),
      .ex_redirect   (ex_redirect),
      .ex_target     (ex_target),
      .id_jump       (id_jump),
      .id_offset     (id_offset),
      .pc_load       (pc_load),
      .pc_next       (pc_next),
      .pc_hold       (pc_hold),
      .flush_if      (flush_if),
      .flush_id      (flush_id),
      .flush_ex      (flush_ex),
      .seq_state     (seq_state)
`ifdef PC_SEQ_PERF_EN
      ,
      .perf_redirects  (perf_redirects),
      .perf_hold_cycles(perf_hold_cycles)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state: mode 0 RUN, 1 PEND, 2 DRAIN; slot priority 0 empty, 1 ID, 2 EX, 3 MEM.
   int          m_mode = 0, n_mode;
   int          m_pri = 0, n_pri;
   logic [31:0] m_tgt = 0, n_tgt;
   longint      m_perf_ld = 0, m_perf_hold = 0;

   logic        e_load, e_hold, e_fif, e_fid, e_fex;
   logic [31:0] e_next;
   logic [1:0]  e_state;

   logic        s_load, s_hold, s_fif, s_fid, s_fex;
   logic [31:0] s_next;
   logic [1:0]  s_state;
   logic [31:0] s_perf_ld;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
      end
   endfunction

   function automatic void model_eval();
      int          best_pri;
      logic [31:0] best_tgt;
      e_load  = 0; e_hold = 0; e_fif = 0; e_fid = 0; e_fex = 0; e_next = 0;
      e_state = 2'(m_mode);
      n_mode  = 0; n_pri = 0; n_tgt = 0;
      if (rst) begin
         e_hold  = 1;
         e_state = 0;
         return;
      end
      best_pri = 0;
      best_tgt = 0;
      if (id_jump && !hazard_stall && m_mode != 2) begin
         best_pri = 1; best_tgt = pc_cur + id_offset - 32'd4;
      end
      if (ex_redirect) begin
         best_pri = 2; best_tgt = ex_target;
      end
      if (mem_mispredict) begin
         best_pri = 3; best_tgt = mem_pc + 32'd4;
      end
      if (m_mode == 1 && m_pri >= best_pri) begin
         best_pri = m_pri; best_tgt = m_tgt;
      end
      if (best_pri == 0) begin
         e_hold = hazard_stall || !imem_ready;
         n_mode = 0;
      end else if (imem_ready) begin
         e_load = 1;
         e_next = best_tgt;
         e_fif  = 1;
         e_fid  = (best_pri >= 2);
         e_fex  = (best_pri == 3);
         n_mode = 2;
      end else begin
         e_hold = 1;
         n_mode = 1;
         n_pri  = best_pri;
         n_tgt  = best_tgt;
      end
   endfunction

   task automatic tick();
      @(negedge clk);
      model_eval();
      s_load = pc_load; s_hold = pc_hold; s_next = pc_next; s_state = seq_state;
      s_fif = flush_if; s_fid = flush_id; s_fex = flush_ex;
      s_perf_ld = 0;
      chk("pc_load", {31'b0, pc_load}, {31'b0, e_load});
      chk("pc_next", pc_next, e_next);
      chk("pc_hold", {31'b0, pc_hold}, {31'b0, e_hold});
      chk("flushes", {29'b0, flush_if, flush_id, flush_ex}, {29'b0, e_fif, e_fid, e_fex});
      chk("seq_state", {30'b0, seq_state}, {30'b0, e_state});
`ifdef PC_SEQ_PERF_EN
      s_perf_ld = perf_redirects;
      chk("perf_redirects", perf_redirects, 32'(m_perf_ld));
      chk("perf_hold_cycles", perf_hold_cycles, 32'(m_perf_hold));
`endif
      @(posedge clk);
      if (rst) begin
         m_perf_ld = 0; m_perf_hold = 0;
      end else begin
         if (e_load && m_perf_ld < 64'hFFFF_FFFF) m_perf_ld++;
         if (e_hold && m_perf_hold < 64'hFFFF_FFFF) m_perf_hold++;
      end
      m_mode = n_mode; m_pri = n_pri; m_tgt = n_tgt;
      #1;
   endtask

   task automatic set_idle();
      rst = 0; imem_ready = 1; hazard_stall = 0;
      mem_mispredict = 0; ex_redirect = 0; id_jump = 0;
   endtask

   initial begin
      pc_cur = 0; mem_pc = 0; ex_target = 0; id_offset = 0;
      set_idle();
      rst = 1;
      tick(); chk("rst_hold", {31'b0, s_hold}, 32'd1);
      tick(); chk("rst_load", {31'b0, s_load}, 32'd0);
      rst = 0;
      tick();
      chk("idle_hold", {31'b0, s_hold}, 32'd0);
      chk("idle_state", {30'b0, s_state}, 32'd0);

      // Early ID jump, then DRAIN ignores a repeat.
      pc_cur = 32'h100; id_offset = 32'h20; id_jump = 1;
      tick();
      chk("id_next", s_next, 32'h11C);
      chk("id_flush", {29'b0, s_fif, s_fid, s_fex}, 32'b100);
      tick();
      chk("drain_state", {30'b0, s_state}, 32'd2);
      chk("drain_noload", {31'b0, s_load}, 32'd0);
      id_jump = 0;
      tick();
      chk("back_run", {30'b0, s_state}, 32'd0);

      // Three-way collision: MEM wins.
      mem_mispredict = 1; mem_pc = 32'h40; ex_redirect = 1; ex_target = 32'h80; id_jump = 1;
      tick();
      chk("mem_next", s_next, 32'h44);
      chk("mem_flush", {29'b0, s_fif, s_fid, s_fex}, 32'b111);
      set_idle();
      tick(); tick();

      // EX parked, MEM replaces it, applies when fetch is ready.
      imem_ready = 0; ex_redirect = 1; ex_target = 32'h200;
      tick();
      chk("pend_hold", {31'b0, s_hold}, 32'd1);
      ex_redirect = 0; mem_mispredict = 1; mem_pc = 32'h300;
      tick();
      chk("pend_state", {30'b0, s_state}, 32'd1);
      mem_mispredict = 0;
      repeat (3) tick();
      imem_ready = 1;
      tick();
      chk("pend_apply", s_next, 32'h304);
      tick();
      chk("pend_drain", {30'b0, s_state}, 32'd2);
      tick();

      // Parked ID overtaken by EX on the release cycle.
      imem_ready = 0; id_jump = 1; pc_cur = 32'h100; id_offset = 32'h20;
      tick();
      id_jump = 0; ex_redirect = 1; ex_target = 32'h500; imem_ready = 1;
      tick();
      chk("ex_over_id", s_next, 32'h500);
      chk("ex_flush", {29'b0, s_fif, s_fid, s_fex}, 32'b110);
      set_idle();
      tick(); tick();
      chk("no_stale_id", {31'b0, s_load}, 32'd0);
`ifdef PC_SEQ_PERF_EN
      chk("perf_four", s_perf_ld, 32'd4);
`endif

      // Load-use stall blocks ID; reset discards a parked slot.
      hazard_stall = 1; id_jump = 1;
      tick();
      chk("stall_hold", {31'b0, s_hold}, 32'd1);
      chk("stall_noload", {31'b0, s_load}, 32'd0);
      set_idle();
      imem_ready = 0; ex_redirect = 1; ex_target = 32'h600;
      tick();
      ex_redirect = 0;
      tick();
      chk("pend_before_rst", {30'b0, s_state}, 32'd1);
      rst = 1;
      tick();
      chk("rst_in_pend", {30'b0, s_state}, 32'd0);
      set_idle();
      tick();
      chk("rst_discard", {31'b0, s_load}, 32'd0);
      tick();

      for (int i = 0; i < 3000; i++) begin
         rst            = ($urandom_range(0, 63) == 0);
         imem_ready     = ($urandom_range(0, 9) < 7);
         hazard_stall   = ($urandom_range(0, 3) == 0);
         mem_mispredict = ($urandom_range(0, 7) == 0);
         ex_redirect    = ($urandom_range(0, 4) == 0);
         id_jump        = ($urandom_range(0, 2) == 0);
         pc_cur         = $urandom;
         mem_pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         ex_target      = $urandom;
         id_offset      = ($urandom_range(0, 3) == 0) ? 32'd2 : $urandom;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
